// File: rtl/series_ctrl_pkg.sv
// Shared types and helpers for the series evaluator controller.
// State encoding is fixed because it is exported on the debug state port.
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_BEGIN = 3'd2,
        S_MULT  = 3'd3,
        S_ADD   = 3'd4
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned terms);
        return $clog2(terms + 1);
    endfunction

    function automatic int unsigned step_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Zero terms behaves as one; requests above the supported maximum saturate.
    function automatic int unsigned calc_n_eff(input int unsigned n, input int unsigned terms);
        if (n == 0)
            return 1;
        if (n > terms)
            return terms;
        return n;
    endfunction

endpackage

// File: rtl/series_ctrl_if.sv
// Control/status bundle between the series controller and its user/datapath.
interface series_ctrl_if #(
    parameter int unsigned TERMS      = 8,
    parameter int unsigned MULT_STEPS = 3
);
    localparam int unsigned CNT_W  = series_ctrl_pkg::cnt_width(TERMS);
    localparam int unsigned STEP_W = series_ctrl_pkg::step_width(MULT_STEPS);

    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  n_terms;
    logic              done;
    logic              busy;
    logic              result_valid;
    logic              ldx;
    logic              init_t;
    logic              ld_t;
    logic              init_r;
    logic              ld_r;
    logic              sel_x;
    logic [CNT_W-1:0]  term_idx;
    logic [STEP_W-1:0] step;
    logic [2:0]        state;

    modport master (
        output start, abort, n_terms,
        input  done, busy, result_valid, ldx, init_t, ld_t, init_r, ld_r,
               sel_x, term_idx, step, state
    );

    modport slave (
        input  start, abort, n_terms,
        output done, busy, result_valid, ldx, init_t, ld_t, init_r, ld_r,
               sel_x, term_idx, step, state
    );
endinterface

// File: rtl/series_step_cnt.sv
// Nested multiply-step / term counter for the series controller.
module series_step_cnt #(
    parameter int unsigned MULT_STEPS = 3,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned STEP_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en_step,
    input  logic              en_term,
    input  logic [CNT_W-1:0]  n_eff,
    output logic [STEP_W-1:0] step,
    output logic [CNT_W-1:0]  term_idx,
    output logic              last_step,
    output logic              last_term
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            step     <= '0;
            term_idx <= '0;
        end else begin
            if (en_step)
                step <= last_step ? '0 : step + STEP_W'(1);
            if (en_term)
                term_idx <= term_idx + CNT_W'(1);
        end
    end

    always_comb begin
        last_step = (step == STEP_W'(MULT_STEPS - 1));
        last_term = (term_idx == n_eff - CNT_W'(1));
    end
endmodule

// File: rtl/series_ctrl.sv
// FSM controller sequencing the x/t/r datapath: r += t, t built by MULT_STEPS multiplies.
module series_ctrl
    import series_ctrl_pkg::*;
#(
    parameter int unsigned TERMS      = 8,
    parameter int unsigned MULT_STEPS = 3
) (
    input  logic           clk,
    input  logic           rst,
    series_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W  = cnt_width(TERMS);
    localparam int unsigned STEP_W = step_width(MULT_STEPS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_eff_q;
    logic              valid_q;
    logic              clr, en_step, en_term, set_valid;
    logic              last_step, last_term;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0]  term_idx;

    series_step_cnt #(
        .MULT_STEPS (MULT_STEPS),
        .CNT_W      (CNT_W),
        .STEP_W     (STEP_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en_step   (en_step),
        .en_term   (en_term),
        .n_eff     (n_eff_q),
        .step      (step),
        .term_idx  (term_idx),
        .last_step (last_step),
        .last_term (last_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_eff_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= set_valid;
            if (state_q == S_INIT)
                n_eff_q <= CNT_W'(calc_n_eff(int'(bus.n_terms), TERMS));
        end
    end

    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        en_step   = 1'b0;
        en_term   = 1'b0;
        set_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr = 1'b1;
                if (bus.start)
                    state_d = S_INIT;
            end
            S_INIT: begin
                clr = 1'b1;
                if (!bus.start)
                    state_d = S_BEGIN;
            end
            S_BEGIN: begin
                clr     = 1'b1;
                state_d = S_MULT;
            end
            S_MULT: begin
                en_step = 1'b1;
                if (last_step)
                    state_d = S_ADD;
            end
            S_ADD: begin
                if (last_term) begin
                    state_d   = S_IDLE;
                    clr       = 1'b1;
                    set_valid = 1'b1;
                end else begin
                    en_term = 1'b1;
                    state_d = S_MULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including completion in the final ADD.
        if (bus.abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            clr       = 1'b1;
            en_step   = 1'b0;
            en_term   = 1'b0;
            set_valid = 1'b0;
        end
    end

    always_comb begin
        bus.done         = (state_q == S_IDLE);
        bus.busy         = (state_q != S_IDLE);
        bus.result_valid = valid_q;
        bus.ldx          = (state_q == S_BEGIN);
        bus.init_t       = (state_q == S_BEGIN);
        bus.init_r       = (state_q == S_BEGIN);
        bus.ld_t         = (state_q == S_BEGIN) || (state_q == S_MULT);
        bus.ld_r         = (state_q == S_BEGIN) || (state_q == S_ADD);
        bus.sel_x        = (state_q == S_MULT) && last_step;
        bus.term_idx     = term_idx;
        bus.step         = step;
        bus.state        = state_q;
    end
endmodule

// File: tb/tb_series_ctrl.sv
// Directed bench for series_ctrl: default (8 terms, 3 steps) and minimal (1 term, 1 step) instances.
module tb_series_ctrl;
    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;

    series_ctrl_if #(.TERMS(8), .MULT_STEPS(3)) i0 ();
    series_ctrl_if #(.TERMS(1), .MULT_STEPS(1)) i1 ();

    series_ctrl #(.TERMS(8), .MULT_STEPS(3)) d0 (.clk(clk), .rst(rst), .bus(i0));
    series_ctrl #(.TERMS(1), .MULT_STEPS(1)) d1 (.clk(clk), .rst(rst), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned strobes0();
        return {i0.ldx, i0.init_t, i0.ld_t, i0.init_r, i0.ld_r, i0.sel_x};
    endfunction

    task automatic check_idle0(input string tag);
        check({tag, "_state"}, i0.state, 0);
        check({tag, "_done_busy"}, {i0.done, i0.busy}, 2'b10);
        check({tag, "_cnt"}, {i0.term_idx, i0.step}, 0);
        check({tag, "_strobes"}, strobes0(), 0);
        check({tag, "_rv"}, i0.result_valid, 0);
    endtask

    // Run on d0; keep_start raises start again during the run to test back-to-back.
    task automatic run_d0(input logic [3:0] n, input int unsigned hold,
                          input int unsigned n_eff, input bit keep_start, input string tag);
        int unsigned lat, exp_lat, p, t, exp_pack;
        i0.n_terms = n;
        i0.start   = 1'b1;
        repeat (hold) @(negedge clk);
        i0.start = 1'b0;
        @(negedge clk);
        check({tag, "_begin_state"}, i0.state, 2);
        check({tag, "_begin_strobes"}, strobes0(), 6'b111110);
        if (keep_start) i0.start = 1'b1;
        exp_lat = 1 + n_eff * 4;
        lat = 0;
        while (!i0.result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!i0.result_valid && lat < exp_lat) begin
                p = (lat - 1) % 4;
                t = (lat - 1) / 4;
                exp_pack = (p < 3) ? {3'd3, 2'(p), 4'(t), (p == 2), 1'b1, 1'b0}
                                   : {3'd4, 2'd0, 4'(t), 1'b0, 1'b0, 1'b1};
                check($sformatf("%s_trace_c%0d", tag, lat),
                      {i0.state, i0.step, i0.term_idx, i0.sel_x, i0.ld_t, i0.ld_r}, exp_pack);
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_end_state_done"}, {i0.state, i0.done, i0.busy}, {3'd0, 1'b1, 1'b0});
        @(negedge clk);
        check({tag, "_rv_single"}, i0.result_valid, 0);
        check({tag, "_after_state"}, i0.state, keep_start ? 1 : 0);
    endtask

    initial begin
        int unsigned k;
        bit seen;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        i0.start = 1'b0; i0.abort = 1'b0; i0.n_terms = '0;
        i1.start = 1'b0; i1.abort = 1'b0; i1.n_terms = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle0("por");

        run_d0(4'd4, 3, 4, 1'b0, "nom4");
        run_d0(4'd0, 1, 1, 1'b0, "n0");
        run_d0(4'd15, 2, 8, 1'b0, "n15");

        // Reset mid-MULT
        i0.n_terms = 4'd4; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_pre_mult", i0.state, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle0("rst");

        // Abort in the final ADD of a 4-term run
        i0.n_terms = 4'd4; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        k = 0;
        while (!(i0.state == 3'd4 && i0.term_idx == 4'd3) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_last_add", (k < 100), 1);
        i0.abort = 1'b1;
        @(negedge clk);
        i0.abort = 1'b0;
        check_idle0("abort");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (i0.result_valid) seen = 1'b1;
        end
        check("abort_no_rv", seen, 0);
        run_d0(4'd4, 1, 4, 1'b0, "post_abort");

        // Back-to-back: start held through completion, then released in INIT
        run_d0(4'd2, 2, 2, 1'b1, "b2b_a");
        run_d0(4'd2, 1, 2, 1'b0, "b2b_b");

        // Minimal instance: one term, one multiply step
        i1.n_terms = 1'b1; i1.start = 1'b1;
        @(negedge clk);
        i1.start = 1'b0;
        @(negedge clk);
        check("min_begin", {i1.state, i1.ldx, i1.init_t, i1.ld_t, i1.init_r, i1.ld_r},
              {3'd2, 5'b11111});
        @(negedge clk);
        check("min_mult", {i1.state, i1.step, i1.sel_x, i1.ld_t, i1.ld_r}, {3'd3, 1'b0, 3'b110});
        @(negedge clk);
        check("min_add", {i1.state, i1.sel_x, i1.ld_t, i1.ld_r}, {3'd4, 3'b001});
        @(negedge clk);
        check("min_rv_at_3", {i1.state, i1.result_valid, i1.done}, {3'd0, 2'b11});
        @(negedge clk);
        check("min_rv_single", i1.result_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
